// File: rtl/mux_sel_pipe_if.sv
// Handshake bundle for mux_sel_pipe: packed input words plus select on the
// upstream side, selected word with its select/error tag on the downstream side.
interface mux_sel_pipe_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 2
);
  localparam int unsigned SEL_W = (NUM_IN <= 2) ? 1 : $clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;

  // Producer/consumer view (testbench or neighbouring pipeline stages)
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_err, out_valid
  );

  // Selector block view
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_err, out_valid
  );
endinterface

// File: rtl/mux_sel_pipe.sv
// Registered N-input word selector with a 2-entry skid buffer.
// Selection happens at accept time; out-of-range selects yield a zero word
// flagged by out_err. in_ready depends only on the state register.
module mux_sel_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 2
) (
  input  logic          clk,
  input  logic          rst,
  mux_sel_pipe_if.slave bus
);
  localparam int unsigned SEL_W = (NUM_IN <= 2) ? 1 : $clog2(NUM_IN);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state;
  logic [WIDTH-1:0] main_data, skid_data, beat_data;
  logic [SEL_W-1:0] main_sel, skid_sel;
  logic             main_err, skid_err, beat_err;
  logic             accept, drain;

  // Word selection for the beat currently presented upstream
  always_comb begin
    beat_data = '0;
    beat_err  = (32'(bus.in_sel) >= NUM_IN);
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (bus.in_sel == SEL_W'(k)) beat_data = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  assign bus.in_ready  = (state != TWO);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = main_data;
  assign bus.out_sel   = main_sel;
  assign bus.out_err   = main_err;

  assign accept = bus.in_valid & bus.in_ready;
  assign drain  = bus.out_valid & bus.out_ready;

  // Occupancy FSM with main/skid entry updates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_data <= '0;
      main_sel  <= '0;
      main_err  <= 1'b0;
      skid_data <= '0;
      skid_sel  <= '0;
      skid_err  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_data <= beat_data;
            main_sel  <= bus.in_sel;
            main_err  <= beat_err;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_data <= beat_data;
            main_sel  <= bus.in_sel;
            main_err  <= beat_err;
          end else if (accept) begin
            skid_data <= beat_data;
            skid_sel  <= bus.in_sel;
            skid_err  <= beat_err;
            state     <= TWO;
          end else if (drain) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            main_data <= skid_data;
            main_sel  <= skid_sel;
            main_err  <= skid_err;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: doc/mux_sel_pipe.md
Name: mux_sel_pipe

Overview:
- Parametrised, registered N-input, W-bit word selector with a valid/ready handshake on both sides.
- Successor to the plain combinational 2:1 byte mux used in the FP adder datapath.
- Used in the exponent, mantissa and operand-swap select stages so that the adder can be pipelined without adding combinational depth.
- A 2-entry skid buffer gives full throughput with a registered in_ready.

Parameters:
- WIDTH, 8, bits per input word and output word (≥1).
- NUM_IN, 2, number of input channels (≥2; need not be a power of two).
- SEL_W (localparam, not overridable), max(1, clog2(NUM_IN)), width of the select field.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  NUM_IN*WIDTH  packed input words; channel k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  channel index to select.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat.
- out_data  out  WIDTH  selected word.
- out_sel  out  SEL_W  in_sel value captured with this beat.
- out_err  out  1  in_sel was ≥ NUM_IN; out_data is forced to 0.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous, active-high.
- Reset values:
  - state = EMPTY; out_valid = 0; out_data = 0; out_sel = 0; out_err = 0; skid register = 0.
  - in_ready = 1 while rst is high, but all inputs are ignored while rst is high.
- Event definitions:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
- Selection is done at accept time:
  - word = in_data[in_sel*WIDTH +: WIDTH] if in_sel < NUM_IN.
  - Otherwise word = 0 and err = 1.
  - {word, in_sel, err} is the captured beat.
- Outputs are driven only from the main register: out_* = main register contents; out_valid = (state != EMPTY).
- in_ready = (state != TWO), decoded from the state register only. There is no combinational path from out_ready to in_ready.
- State transitions:
  - EMPTY: accept -> main <= beat, go to ONE.
  - ONE:
    - accept & drain -> main <= beat, stay in ONE.
    - accept & !drain -> skid <= beat, go to TWO.
    - !accept & drain -> go to EMPTY.
    - Otherwise hold.
  - TWO (in_ready = 0): drain -> main <= skid, go to ONE. Otherwise hold.
- Latency: an accepted beat appears on out_* in the next cycle when the block is in EMPTY, or in ONE with a simultaneous drain.
- Throughput: 1 beat/cycle sustained while out_ready is held high.
- Ordering: beats leave in acceptance order. None are lost or duplicated.
- Stability: while out_valid = 1 and out_ready = 0, out_data, out_sel and out_err must not change.
- Data hygiene: when state is EMPTY, out_data holds its last value. Checkers qualify out_data with out_valid.
- Reset mid-operation: rst asserted in ONE or TWO drops out_valid immediately (asynchronous) and discards both entries. in_valid is ignored until the first edge after rst deasserts.
- Upstream rule: once in_valid is raised, upstream holds the beat stable until accept. The block does not check this.

Test Plan:
- Reset/idle: assert rst with in_valid = 1 -> out_valid = 0, out_data = 0, out_err = 0. Release rst -> first accept occurs on the next edge.
- Basic select (WIDTH = 8, NUM_IN = 2, matching the legacy configuration): in_data = {8'hA5, 8'h3C}, in_sel = 1, out_ready = 1 -> one cycle later out_data = 8'hA5, out_sel = 1, out_valid = 1. in_sel = 0 -> 8'h3C.
- Streaming (WIDTH = 32, NUM_IN = 4): 16 back-to-back beats with rotating sel, out_ready = 1 -> 16 outputs in 16 consecutive cycles, in order, in_ready never low.
- Backpressure:
  - Hold out_ready = 0 while presenting beats 1, 2, 3 -> beat 1 is held on the output, beat 2 goes to skid, in_ready = 0, and beat 3 is not accepted.
  - Release out_ready -> outputs 1, 2, 3 in order, with no gaps after the first.
- Out-of-range select (NUM_IN = 3, SEL_W = 2): in_sel = 3 with all inputs = 8'hFF -> out_data = 0, out_err = 1, out_sel = 3. The next beat with in_sel = 2 has out_err = 0.
- Reset mid-operation: fill to TWO, then pulse rst asynchronously between clock edges -> out_valid falls immediately. After release no stale beat is emitted and in_ready = 1.
